// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module   : uart_rx_fifo
// Purpose  : First-word-fall-through byte FIFO on the UART receive-to-transmit
//            echo path, with sticky overrun and optional parity-error flags.
//            Optional parity check: define UART_RX_FIFO_PARITY_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_parity,
  input  logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overrun,
  output logic                  parity_err,
  input  logic                  flag_clr
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic                overrun_q, overrun_d;

  logic w_parity_ok;
  logic w_push;
  logic w_pop;
  logic w_ovr_set;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {ADDR_WIDTH{1'b0}}});
  assign count    = wr_ptr_q - rd_ptr_q;
  assign tx_valid = !empty;
  // Gated so the output reads zero straight out of reset instead of stale RAM.
  assign tx_data  = empty ? '0 : mem[rd_ptr_q[ADDR_WIDTH-1:0]];
  assign overrun  = overrun_q;

`ifdef UART_RX_FIFO_PARITY_CHECK_EN
  logic parity_err_q, parity_err_d;
  logic w_par_set;

  assign w_parity_ok = (rx_parity == ((^rx_data) ^ (PARITY_ODD != 0)));
  assign w_par_set   = rx_valid && !w_parity_ok;
  assign parity_err  = parity_err_q;

  always_comb begin
    parity_err_d = parity_err_q;
    if (w_par_set)     parity_err_d = 1'b1;
    else if (flag_clr) parity_err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err_q <= 1'b0;
    else     parity_err_q <= parity_err_d;
  end
`else
  logic unused_parity_cfg;

  assign unused_parity_cfg = rx_parity ^ (PARITY_ODD != 0);
  assign w_parity_ok       = 1'b1;
  assign parity_err        = 1'b0;
`endif

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_pop     = tx_valid && tx_ready;
  assign w_push    = rx_valid && w_parity_ok && (!full || w_pop);
  assign w_ovr_set = rx_valid && w_parity_ok && full && !w_pop;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    overrun_d = overrun_q;
    if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (w_ovr_set)     overrun_d = 1'b1;
    else if (flag_clr) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= rx_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module   : tb_uart_rx_fifo
// Purpose  : Self-checking bench for uart_rx_fifo against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

  localparam int DW         = 8;
  localparam int AW         = 4;
  localparam int DEPTH      = 16;
  localparam int PARITY_ODD = 0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] rx_data = '0;
  logic          rx_parity = 1'b0;
  logic          rx_valid = 1'b0;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b0;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          overrun;
  logic          parity_err;
  logic          flag_clr = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DW-1:0] m_q[$];
  logic          m_ovr = 1'b0;
  logic          m_par = 1'b0;

  uart_rx_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .PARITY_ODD(PARITY_ODD)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_parity (rx_parity),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overrun   (overrun),
    .parity_err(parity_err),
    .flag_clr  (flag_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Parity bit the sender would attach: odd number of ones gives 1 for even parity.
  function automatic logic good_par(input logic [DW-1:0] d);
    return logic'(($countones(d) % 2) == 1) ^ logic'(PARITY_ODD != 0);
  endfunction

  task automatic check_state();
    chk("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
    chk("count",    32'(count),    32'(m_q.size()));
    chk("full",     32'(full),     32'(m_q.size() == DEPTH));
    chk("empty",    32'(empty),    32'(m_q.size() == 0));
    chk("overrun",  32'(overrun),  32'(m_ovr));
    chk("parity_err", 32'(parity_err), 32'(m_par));
    if (m_q.size() != 0) chk("tx_data", 32'(tx_data), 32'(m_q[0]));
  endtask

  task automatic step(input logic rv, input logic [DW-1:0] d, input logic p,
                      input logic rdy, input logic clr);
    int  sz;
    logic pop, pok, push;
    @(negedge clk);
    check_state();
    rx_valid  = rv;
    rx_data   = d;
    rx_parity = p;
    tx_ready  = rdy;
    flag_clr  = clr;
    @(posedge clk);
    sz  = m_q.size();
    pop = (sz > 0) && rdy;
`ifdef UART_RX_FIFO_PARITY_CHECK_EN
    pok = (p == good_par(d));
`else
    pok = 1'b1;
`endif
    push = rv && pok && ((sz < DEPTH) || pop);
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back(d);
    if (rv && pok && (sz == DEPTH) && !pop) m_ovr = 1'b1;
    else if (clr)                           m_ovr = 1'b0;
    if (rv && !pok) m_par = 1'b1;
    else if (clr)   m_par = 1'b0;
  endtask

  task automatic push_byte(input logic [DW-1:0] d, input logic rdy);
    step(1'b1, d, good_par(d), rdy, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 8'h00, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data",  32'(tx_data),  32'd0);
    chk("rst_empty",    32'(empty),    32'd1);
    chk("rst_full",     32'(full),     32'd0);
    chk("rst_count",    32'(count),    32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Three pushes with the transmitter stalled, then drain
    push_byte(8'h41, 1'b0);
    push_byte(8'h42, 1'b0);
    push_byte(8'h43, 1'b0);
    idle(1'b0);
    repeat (4) idle(1'b1);

    // Fill to full, overrun with 0xFF, drain
    for (int i = 0; i < DEPTH; i++) push_byte(8'(i), 1'b0);
    push_byte(8'hFF, 1'b0);
    idle(1'b0);
    chk("ovr_set", 32'(overrun), 32'd1);
    repeat (DEPTH + 1) idle(1'b1);

    // Push and pop together at full: no overrun, 0xAA lands at the tail
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h60 + i), 1'b0);
    push_byte(8'hAA, 1'b1);
    idle(1'b0);
    chk("full_pp_ovr", 32'(overrun), 32'd0);
    repeat (DEPTH + 1) idle(1'b1);

    // Streaming across two pointer wraps
    for (int i = 0; i < 40; i++) begin
      push_byte(8'($urandom), 1'b1);
      chk("stream_cnt_le1", 32'(count <= 1), 32'd1);
    end
    idle(1'b1);

`ifdef UART_RX_FIFO_PARITY_CHECK_EN
    step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h07, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    chk("par_err_set", 32'(parity_err), 32'd1);
    chk("par_cnt",     32'(count),      32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    idle(1'b0);
    chk("par_err_clr", 32'(parity_err), 32'd0);
`endif

    // Asynchronous reset mid-stream, with overrun set beforehand
    for (int i = 0; i < DEPTH; i++) push_byte(8'(8'h20 + i), 1'b0);
    push_byte(8'hEE, 1'b0);
    repeat (DEPTH - 5) idle(1'b1);
    idle(1'b0);
    chk("pre_rst_cnt", 32'(count), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_tx_valid", 32'(tx_valid), 32'd0);
    chk("arst_count",    32'(count),    32'd0);
    chk("arst_overrun",  32'(overrun),  32'd0);
    m_q.delete();
    m_ovr = 1'b0;
    m_par = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    push_byte(8'h55, 1'b0);
    idle(1'b0);
    chk("post_rst_data", 32'(tx_data), 32'h55);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [DW-1:0] d;
      logic          p;
      d = 8'($urandom);
      p = ($urandom_range(0, 7) == 0) ? ~good_par(d) : good_par(d);
      step(logic'($urandom_range(0, 99) < 55), d, p,
           logic'($urandom_range(0, 99) < 45),
           logic'($urandom_range(0, 49) == 0));
    end
    idle(1'b0);
    @(negedge clk);
    check_state();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
